// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared ALU, with a registered response and condition codes.
// Latency: 1 cycle from accept to resp_valid; a new accept can replace the held response on the edge it is consumed.
// Backpressure: resp_ready=0 in HOLD freezes resp_* and forces both reqN_ready low.
//
// Ports: clk/rst (sync, active-high); reqN_valid/reqN_ready handshake per requester with
// reqN_num1/num2 (64b), reqN_op (00 add, 01 sub, 10 and, 11 xor), reqN_set_cc;
// resp_valid/resp_ready with resp_port, resp_result, resp_overflow; cc_zf/cc_sf/cc_of; op_count.

// Combinational 64-bit ALU: add, sub, and, xor. Overflow is signed overflow for add/sub, 0 otherwise.
module alu (
  input  logic [63:0] num1,
  input  logic [63:0] num2,
  input  logic [1:0]  operation,
  output logic [63:0] result,
  output logic        overflow_flag
);
  always_comb begin
    result        = '0;
    overflow_flag = 1'b0;
    unique case (operation)
      2'b00: begin
        result        = num1 + num2;
        // Operands of equal sign producing a result of the other sign.
        overflow_flag = (num1[63] == num2[63]) && (result[63] != num1[63]);
      end
      2'b01: begin
        result        = num1 - num2;
        // Operands of differing sign where the result takes the subtrahend's sign.
        overflow_flag = (num1[63] != num2[63]) && (result[63] != num1[63]);
      end
      2'b10:   result = num1 & num2;
      default: result = num1 ^ num2;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_num1,
  input  logic [63:0] req0_num2,
  input  logic [1:0]  req0_op,
  input  logic        req0_set_cc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_num1,
  input  logic [63:0] req1_num2,
  input  logic [1:0]  req1_op,
  input  logic        req1_set_cc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_port,
  output logic [63:0] resp_result,
  output logic        resp_overflow,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic [15:0] op_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] port_t;

  typedef struct packed {
    logic [63:0] num1;
    logic [63:0] num2;
    logic [1:0]  op;
    logic        set_cc;
  } alu_req_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t   state, state_nxt;
  port_t    last_grant;
  port_t    grant;
  logic     can_accept;
  logic     accept;
  alu_req_t req0_dat, req1_dat, sel_dat;
  logic [63:0] alu_result;
  logic        alu_overflow;

  assign req0_dat = '{num1: req0_num1, num2: req0_num2, op: req0_op, set_cc: req0_set_cc};
  assign req1_dat = '{num1: req1_num1, num2: req1_num2, op: req1_op, set_cc: req1_set_cc};

  // Arbitration, handshake and next state.
  always_comb begin
    grant      = '0;
    can_accept = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    state_nxt  = state;

    can_accept = (state == IDLE) || resp_ready;

    // Round-robin on a tie: the port that did not win last time.
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = port_t'(1);
    else                          grant = port_t'(0);

    // Ready is suppressed during reset so no requester sees a phantom accept.
    req0_ready = !rst && can_accept && req0_valid && (grant == port_t'(0));
    req1_ready = !rst && can_accept && req1_valid && (grant == port_t'(1));
    accept     = req0_ready || req1_ready;

    if (accept)                                  state_nxt = HOLD;
    else if ((state == HOLD) && resp_ready)      state_nxt = IDLE;
  end

  // Operand mux is driven by grant alone; the ready gating above decides whether the result is used.
  assign sel_dat = (grant == port_t'(1)) ? req1_dat : req0_dat;

  alu u_alu (
    .num1          (sel_dat.num1),
    .num2          (sel_dat.num2),
    .operation     (sel_dat.op),
    .result        (alu_result),
    .overflow_flag (alu_overflow)
  );

  assign resp_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= port_t'(1);
      resp_port     <= 1'b0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      cc_zf         <= 1'b0;
      cc_sf         <= 1'b0;
      cc_of         <= 1'b0;
      op_count      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        resp_port     <= grant;
        resp_result   <= alu_result;
        resp_overflow <= alu_overflow;
        last_grant    <= grant;
        op_count      <= op_count + 16'd1;
        if (sel_dat.set_cc) begin
          cc_zf <= (alu_result == 64'd0);
          cc_sf <= alu_result[63];
          cc_of <= alu_overflow;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reference model of arbitration, ALU, cc and count,
// with expected responses queued at accept and compared while the DUT holds them.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_num1, req0_num2, req1_num1, req1_num2;
  logic [1:0]  req0_op, req1_op;
  logic        req0_set_cc, req1_set_cc;
  logic        resp_valid, resp_ready, resp_port;
  logic [63:0] resp_result;
  logic        resp_overflow;
  logic        cc_zf, cc_sf, cc_of;
  logic [15:0] op_count;

  alu_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num1(req0_num1),
    .req0_num2(req0_num2), .req0_op(req0_op), .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num1(req1_num1),
    .req1_num2(req1_num2), .req1_op(req1_op), .req1_set_cc(req1_set_cc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [63:0] result;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   acc_ports[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state.
  logic        m_hold, m_last, m_zf, m_sf, m_of;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Independent arithmetic: 65-bit sign-extended sum/difference; overflow when the top two bits differ.
  task automatic alu_model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                           output logic [63:0] r, output logic ov);
    logic [64:0] w;
    w  = '0;
    ov = 1'b0;
    case (op)
      2'b00: begin w = {a[63], a} + {b[63], b}; r = w[63:0]; ov = w[64] ^ w[63]; end
      2'b01: begin w = {a[63], a} - {b[63], b}; r = w[63:0]; ov = w[64] ^ w[63]; end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
  endtask

  // One clock: check handshake before the edge, advance the model, check outputs after the edge.
  task automatic tick();
    logic        can, g, e0, e1, acc, scc, ov;
    logic [63:0] r;
    exp_t        e;
    @(negedge clk);
    can = !m_hold || resp_ready;
    g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    e0  = !rst && can && req0_valid && !g;
    e1  = !rst && can && req1_valid && g;
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
    acc = e0 || e1;
    scc = e1 ? req1_set_cc : req0_set_cc;
    if (e1) alu_model(req1_num1, req1_num2, req1_op, r, ov);
    else    alu_model(req0_num1, req0_num2, req0_op, r, ov);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_hold = 0; m_last = 1; m_zf = 0; m_sf = 0; m_of = 0; m_cnt = 0;
    end else begin
      if (m_hold && resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        e.port = e1; e.result = r; e.ovf = ov;
        sb.push_back(e);
        acc_ports.push_back(int'(e1));
        m_hold = 1;
        m_last = e1;
        m_cnt  = m_cnt + 16'd1;
        if (scc) begin m_zf = (r == 64'd0); m_sf = r[63]; m_of = ov; end
      end else if (m_hold && resp_ready) begin
        m_hold = 0;
      end
    end
    chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_hold});
    chk("op_count", {48'd0, op_count}, {48'd0, m_cnt});
    chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    if (m_hold && sb.size() > 0) begin
      chk("resp_port", {63'd0, resp_port}, {63'd0, sb[0].port});
      chk("resp_result", resp_result, sb[0].result);
      chk("resp_overflow", {63'd0, resp_overflow}, {63'd0, sb[0].ovf});
    end
  endtask

  task automatic drive(input logic v0, input logic [63:0] a0, input logic [63:0] b0, input logic [1:0] o0,
                       input logic c0, input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                       input logic [1:0] o1, input logic c1);
    req0_valid = v0; req0_num1 = a0; req0_num2 = b0; req0_op = o0; req0_set_cc = c0;
    req1_valid = v1; req1_num1 = a1; req1_num2 = b1; req1_op = o1; req1_set_cc = c1;
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] t;
    case ($urandom_range(0, 6))
      0: t = 64'h7FFF_FFFF_FFFF_FFFF;
      1: t = 64'h8000_0000_0000_0000;
      2: t = 64'd0;
      3: t = '1;
      4: t = 64'd5;
      default: t = {$urandom(), $urandom()};
    endcase
    return t;
  endfunction

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    m_hold = 0; m_last = 1; m_zf = 0; m_sf = 0; m_of = 0; m_cnt = 0;
    rst = 1; resp_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset two cycles, release: all outputs zero.
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_result", resp_result, 64'd0);
    chk("rst_port", {63'd0, resp_port}, 64'd0);

    // Port 0 signed-overflowing add with set_cc.
    resp_ready = 1;
    drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1, 0, 0, 0, 0, 0);
    tick();
    chk("ovf_result", resp_result, 64'h8000_0000_0000_0000);
    chk("ovf_flag", {63'd0, resp_overflow}, 64'd1);
    chk("ovf_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Both ports valid for four cycles after a fresh reset: order 0,1,0,1, count 4.
    rst = 1; tick(); rst = 0;
    acc_ports.delete();
    drive(1, 64'd10, 64'd3, 2'b01, 0, 1, 64'hF0, 64'h3C, 2'b11, 0);
    repeat (4) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rr_count", {48'd0, op_count}, 64'd4);
    chk("rr_accepts", acc_ports.size(), 64'd4);
    for (int i = 0; i < 4 && i < acc_ports.size(); i++)
      chk("rr_order", acc_ports[i], exp_order[i]);

    // Backpressure: response pending, resp_ready low for three cycles with both ports requesting.
    resp_ready = 0;
    drive(1, 64'd7, 64'd2, 2'b00, 1, 0, 0, 0, 0, 0);   // result 9 sets cc_zf=0
    tick();
    drive(1, 64'd1, 64'd1, 2'b10, 1, 1, 64'd2, 64'd2, 2'b01, 1);
    repeat (3) tick();
    chk("bp_count", {48'd0, op_count}, 64'd5);
    chk("bp_result", resp_result, 64'd9);
    resp_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Port 1 sub 5-5: set_cc=0 leaves cc_zf at 0, set_cc=1 sets it.
    drive(0, 0, 0, 0, 0, 1, 64'd5, 64'd5, 2'b01, 0);
    tick();
    chk("sub_result", resp_result, 64'd0);
    chk("sub_zf_kept", {63'd0, cc_zf}, 64'd0);
    drive(0, 0, 0, 0, 0, 1, 64'd5, 64'd5, 2'b01, 1);
    tick();
    chk("sub_zf_set", {63'd0, cc_zf}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset while holding a response.
    resp_ready = 0;
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b11, 1, 0, 0, 0, 0, 0);
    tick();
    rst = 1;
    tick();
    chk("rh_valid", {63'd0, resp_valid}, 64'd0);
    chk("rh_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd0);
    chk("rh_count", {48'd0, op_count}, 64'd0);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Random traffic, including operand changes while waiting and occasional reset.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0, pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      resp_ready = $urandom_range(0, 3) != 0;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
